// File: rtl/pcs_pkg.sv
// Shared PCS receive-path definitions.
// Provides the 64b/66b sync-header encodings, default block-lock thresholds,
// the block-lock state type, and a sync-header validity helper.
package pcs_pkg;

    // Legal 64b/66b sync headers: data block and control block
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Default block-lock thresholds
    localparam int unsigned SH_CNT_MAX_DEF     = 64;
    localparam int unsigned SH_INVALID_MAX_DEF = 16;
    localparam int unsigned SLIP_WAIT_DEF      = 32;

    // Block-lock FSM states (prefixed so they cannot clash with the SLIP_WAIT parameter)
    typedef enum logic [0:0] {
        LS_TEST      = 1'b0,
        LS_SLIP_WAIT = 1'b1
    } lock_state_t;

    // A header is valid only when its two bits differ (01 or 10)
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_block_lock.sv
// 64b/66b block synchroniser for the receive path.
// Watches the 2-bit sync header of each block delivered by the RX gearbox,
// requests single-bit slips until headers line up, and reports block lock.
// Ports:
//   i_rxc             receive clock (gearbox word rate)
//   i_reset_n         asynchronous active-low reset
//   i_init_done       transceiver init complete; 0 holds the block in reset (synchronous)
//   i_rx_header       sync header of the current block
//   i_rx_header_valid qualifies i_rx_header; one header evaluated per qualified cycle
//   o_block_lock      alignment acquired (registered)
//   o_slip            one-cycle bitslip request to the gearbox (registered)
//   o_slip_count      saturating number of slips since reset (registered)
module rx_block_lock
    import pcs_pkg::*;
#(
    parameter int unsigned SH_CNT_MAX     = SH_CNT_MAX_DEF,
    parameter int unsigned SH_INVALID_MAX = SH_INVALID_MAX_DEF,
    parameter int unsigned SLIP_WAIT      = SLIP_WAIT_DEF
) (
    input  logic        i_rxc,
    input  logic        i_reset_n,
    input  logic        i_init_done,
    input  logic [1:0]  i_rx_header,
    input  logic        i_rx_header_valid,
    output logic        o_block_lock,
    output logic        o_slip,
    output logic [15:0] o_slip_count
);

    localparam int unsigned SH_CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned SH_INV_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int unsigned SH_WAIT_W = $clog2(SLIP_WAIT + 1);

    lock_state_t          state_r, state_nxt_s;
    logic [SH_CNT_W-1:0]  sh_cnt_r, sh_cnt_nxt_s, sh_cnt_inc_s;
    logic [SH_INV_W-1:0]  sh_inv_r, sh_inv_nxt_s, sh_inv_inc_s;
    logic [SH_WAIT_W-1:0] wait_r, wait_nxt_s, wait_inc_s;
    logic                 block_lock_r, block_lock_nxt_s;
    logic                 slip_r, slip_nxt_s;
    logic [15:0]          slip_count_r, slip_count_nxt_s;
    logic                 sh_valid_s, win_done_s, slip_act_s, wait_done_s;

    // Header classification, counter increments and terminal conditions
    always_comb begin
        sh_valid_s   = sh_is_valid(i_rx_header);
        sh_cnt_inc_s = sh_cnt_r + SH_CNT_W'(1);
        sh_inv_inc_s = sh_inv_r + SH_INV_W'(1);
        wait_inc_s   = wait_r + SH_WAIT_W'(1);
        win_done_s   = (sh_cnt_inc_s == SH_CNT_W'(SH_CNT_MAX));
        wait_done_s  = (wait_inc_s == SH_WAIT_W'(SLIP_WAIT));
        // Slip on any bad header while unlocked, or on the threshold bad header;
        // this takes priority over a window completing on the same header.
        slip_act_s   = i_rx_header_valid && (state_r == LS_TEST) && !sh_valid_s &&
                       (!block_lock_r || (sh_inv_inc_s == SH_INV_W'(SH_INVALID_MAX)));
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (i_rx_header_valid) begin
            case (state_r)
                LS_TEST: begin
                    if (slip_act_s) state_nxt_s = LS_SLIP_WAIT;
                    else            state_nxt_s = LS_TEST;
                end
                LS_SLIP_WAIT: begin
                    if (wait_done_s) state_nxt_s = LS_TEST;
                    else             state_nxt_s = LS_SLIP_WAIT;
                end
                default: state_nxt_s = LS_TEST;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of counters and registered outputs
    always_comb begin
        sh_cnt_nxt_s     = sh_cnt_r;
        sh_inv_nxt_s     = sh_inv_r;
        wait_nxt_s       = wait_r;
        block_lock_nxt_s = block_lock_r;
        slip_nxt_s       = 1'b0;
        slip_count_nxt_s = slip_count_r;
        if (i_rx_header_valid) begin
            case (state_r)
                LS_TEST: begin
                    if (slip_act_s) begin
                        block_lock_nxt_s = 1'b0;
                        slip_nxt_s       = 1'b1;
                        if (slip_count_r != 16'hFFFF) slip_count_nxt_s = slip_count_r + 16'd1;
                        else                          slip_count_nxt_s = slip_count_r;
                        sh_cnt_nxt_s     = '0;
                        sh_inv_nxt_s     = '0;
                        wait_nxt_s       = '0;
                    end else if (win_done_s) begin
                        // A window with no bad headers grants lock; otherwise lock is kept as is
                        if (sh_valid_s && (sh_inv_r == '0)) block_lock_nxt_s = 1'b1;
                        else                                block_lock_nxt_s = block_lock_r;
                        sh_cnt_nxt_s = '0;
                        sh_inv_nxt_s = '0;
                    end else begin
                        sh_cnt_nxt_s = sh_cnt_inc_s;
                        if (sh_valid_s) sh_inv_nxt_s = sh_inv_r;
                        else            sh_inv_nxt_s = sh_inv_inc_s;
                    end
                end
                LS_SLIP_WAIT: begin
                    // Headers are ignored while the gearbox settles after a slip
                    if (wait_done_s) begin
                        wait_nxt_s   = '0;
                        sh_cnt_nxt_s = '0;
                        sh_inv_nxt_s = '0;
                    end else begin
                        wait_nxt_s = wait_inc_s;
                    end
                end
                default: begin
                    sh_cnt_nxt_s     = '0;
                    sh_inv_nxt_s     = '0;
                    wait_nxt_s       = '0;
                    block_lock_nxt_s = 1'b0;
                end
            endcase
        end else begin
            slip_nxt_s = 1'b0;
        end
    end

    // State and output registers; i_init_done low acts as a synchronous clear
    always_ff @(posedge i_rxc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= LS_TEST;
            sh_cnt_r     <= '0;
            sh_inv_r     <= '0;
            wait_r       <= '0;
            block_lock_r <= 1'b0;
            slip_r       <= 1'b0;
            slip_count_r <= 16'd0;
        end else if (!i_init_done) begin
            state_r      <= LS_TEST;
            sh_cnt_r     <= '0;
            sh_inv_r     <= '0;
            wait_r       <= '0;
            block_lock_r <= 1'b0;
            slip_r       <= 1'b0;
            slip_count_r <= 16'd0;
        end else begin
            state_r      <= state_nxt_s;
            sh_cnt_r     <= sh_cnt_nxt_s;
            sh_inv_r     <= sh_inv_nxt_s;
            wait_r       <= wait_nxt_s;
            block_lock_r <= block_lock_nxt_s;
            slip_r       <= slip_nxt_s;
            slip_count_r <= slip_count_nxt_s;
        end
    end

    assign o_block_lock = block_lock_r;
    assign o_slip       = slip_r;
    assign o_slip_count = slip_count_r;

endmodule

// File: tb/tb_rx_block_lock.sv
// Self-checking bench for rx_block_lock: directed scenarios followed by
// randomized header streams, compared against a behavioural model.
module tb_rx_block_lock;

    logic        i_rxc = 1'b0;
    logic        i_reset_n;
    logic        i_init_done;
    logic [1:0]  i_rx_header;
    logic        i_rx_header_valid;
    logic        o_block_lock;
    logic        o_slip;
    logic [15:0] o_slip_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic m_lock;
    logic m_slip;
    int   m_slips;
    int   m_win;        // headers seen in the current window
    int   m_bad;        // bad headers seen in the current window
    int   m_wait_left;  // strobes still to be ignored after a slip

    rx_block_lock dut (
        .i_rxc             (i_rxc),
        .i_reset_n         (i_reset_n),
        .i_init_done       (i_init_done),
        .i_rx_header       (i_rx_header),
        .i_rx_header_valid (i_rx_header_valid),
        .o_block_lock      (o_block_lock),
        .o_slip            (o_slip),
        .o_slip_count      (o_slip_count)
    );

    always #5 i_rxc = ~i_rxc;

    task automatic model_clear();
        m_lock = 1'b0; m_slip = 1'b0; m_slips = 0;
        m_win = 0; m_bad = 0; m_wait_left = 0;
    endtask

    task automatic model_strobe(input logic [1:0] h);
        bit good;
        m_slip = 1'b0;
        if (m_wait_left > 0) begin
            m_wait_left--;
        end else begin
            good = (h == 2'b01) || (h == 2'b10);
            m_win++;
            if (!good) m_bad++;
            if (!good && (!m_lock || m_bad == 16)) begin
                m_lock = 1'b0;
                m_slip = 1'b1;
                if (m_slips < 65535) m_slips++;
                m_win = 0; m_bad = 0;
                m_wait_left = 32;
            end else if (m_win == 64) begin
                if (m_bad == 0) m_lock = 1'b1;
                m_win = 0; m_bad = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        n_vec++;
        assert (o_block_lock === m_lock) else begin
            n_err++;
            $error("FAIL %s lock: observed %0b expected %0b", tag, o_block_lock, m_lock);
        end
        n_vec++;
        assert (o_slip === m_slip) else begin
            n_err++;
            $error("FAIL %s slip: observed %0b expected %0b", tag, o_slip, m_slip);
        end
        n_vec++;
        assert (o_slip_count === 16'(m_slips)) else begin
            n_err++;
            $error("FAIL %s slip_count: observed %0d expected %0d", tag, o_slip_count, m_slips);
        end
    endtask

    task automatic expect_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic expect_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic v, input logic [1:0] h, input string tag);
        i_rx_header_valid = v;
        i_rx_header       = h;
        @(posedge i_rxc);
        #1;
        if (!i_init_done) model_clear();
        else if (v)       model_strobe(h);
        else              m_slip = 1'b0;
        check_outputs(tag);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic do_reset();
        i_reset_n = 1'b0;
        #2;
        model_clear();
        check_outputs("reset");
        @(negedge i_rxc);
        i_reset_n = 1'b1;
    endtask

    initial begin
        i_reset_n         = 1'b0;
        i_init_done       = 1'b1;
        i_rx_header       = 2'b00;
        i_rx_header_valid = 1'b0;
        model_clear();
        @(posedge i_rxc); #1;
        do_reset();

        // 1: clean acquisition after exactly 64 headers
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 2'b01, "acq");
            if (i == 62) expect_bit("acq_lock_after_63", o_block_lock, 1'b0);
        end
        expect_bit("acq_lock_after_64", o_block_lock, 1'b1);
        expect_cnt("acq_no_slips", o_slip_count, 16'd0);

        // 2: unlocked slip on 5th header, 32 ignored strobes, then lock
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, "pre_slip");
        step(1'b1, 2'b11, "slip5");
        expect_bit("slip5_pulse", o_slip, 1'b1);
        expect_cnt("slip5_count", o_slip_count, 16'd1);
        for (int i = 0; i < 32; i++) step(1'b1, 2'b00, "slip_wait");
        for (int i = 0; i < 64; i++) step(1'b1, 2'b10, "relock");
        expect_bit("relock_lock", o_block_lock, 1'b1);

        // 3: 15 bad headers in a window keep lock; 16 force a slip
        for (int i = 0; i < 64; i++)
            step(1'b1, ((i % 4 == 1) && (i < 60)) ? 2'b00 : 2'b01, "bad15");
        expect_bit("bad15_lock", o_block_lock, 1'b1);
        expect_cnt("bad15_no_slip", o_slip_count, 16'd1);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, (i % 4 == 1) ? 2'b11 : 2'b10, "bad16");
            if (i == 61) expect_bit("bad16_slip", o_slip, 1'b1);
        end
        expect_bit("bad16_unlocked", o_block_lock, 1'b0);
        expect_cnt("bad16_count", o_slip_count, 16'd2);
        for (int i = 0; i < 96; i++) step(1'b1, 2'b01, "recover");
        expect_bit("recover_lock", o_block_lock, 1'b1);

        // 4: single bad header in a window, then a clean window
        for (int i = 0; i < 64; i++) step(1'b1, (i == 10) ? 2'b00 : 2'b10, "bad1");
        for (int i = 0; i < 64; i++) step(1'b1, 2'b01, "clean");
        expect_bit("clean_lock", o_block_lock, 1'b1);
        expect_cnt("clean_count", o_slip_count, 16'd2);

        // 5: header valid toggling, idle cycles do not count
        do_reset();
        for (int i = 0; i < 128; i++) begin
            step((i % 2) == 0, 2'b01, "toggle");
            if (i == 125) expect_bit("toggle_lock_early", o_block_lock, 1'b0);
        end
        expect_bit("toggle_lock", o_block_lock, 1'b1);

        // 6: async reset mid-window while locked, then init_done hold
        for (int i = 0; i < 10; i++) step(1'b1, 2'b01, "mid");
        expect_bit("mid_locked", o_block_lock, 1'b1);
        i_reset_n = 1'b0;
        #1;
        expect_bit("async_reset_lock", o_block_lock, 1'b0);
        #1;
        model_clear();
        @(negedge i_rxc);
        i_reset_n = 1'b1;
        for (int i = 0; i < 74; i++) step(1'b1, 2'b10, "pre_init");
        expect_bit("pre_init_lock", o_block_lock, 1'b1);
        i_init_done = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, "init_hold");
        expect_bit("init_hold_lock", o_block_lock, 1'b0);
        i_init_done = 1'b1;
        for (int i = 0; i < 64; i++) step(1'b1, 2'b01, "init_relock");
        expect_bit("init_relock_lock", o_block_lock, 1'b1);

        // 7: randomized streams with alternating low and high error rates
        for (int ph = 0; ph < 6; ph++) begin
            int rate;
            rate = (ph % 2 == 1) ? 6 : 300;
            for (int i = 0; i < 600; i++) begin
                logic v;
                logic [1:0] h;
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, rate - 1) == 0) h = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                else                                  h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                step(v, h, "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
